alu_share_ctrl: RTL

Controller that shares the single registered 32-bit ALU between N requesters, for example the PC-increment path, the execute stage and the branch comparator.
- Per-requester valid/ready request and response handshakes.
- Round-robin arbitration.
- Sequences one operation at a time through the ALU's one-cycle registered result.
- Returns result and zero flag to the granted requester.

---
 rtl/alu_share_pkg.sv | 29 ++
 rtl/alu_share_ctrl_rr_arbiter.sv | 46 ++++
 rtl/alu_share_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_pkg
// Shared definitions for the ALU sharing controller: ALU op codes, the
// controller FSM state encoding and an op-code legality helper.
// -----------------------------------------------------------------------------
package alu_share_pkg;

  // Bit 2 of the op code selects inverted b with carry-in 1 (SUB, SLT).
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after ptr, wrapping modulo N_REQ. The pointer register lives in the parent.
//
// Ports:
//   req         in   N_REQ  request vector
//   ptr         in   IDX_W  highest-priority index this cycle
//   en          in   1      when low no grant is produced
//   grant       out  N_REQ  one-hot grant (or zero)
//   idx         out  IDX_W  encoded index of the granted request
//   grant_valid out  1      a grant was produced
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             grant_valid
);

  int cand;

  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant       = '0;
    idx         = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (en && !grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
// Shares one registered ALU between N_REQ requesters. A round-robin winner is
// accepted in IDLE, its operation is sequenced through the ALU (EXEC drives
// the ALU, CAPT captures its registered result) and the result is returned
// on the winner's response handshake in RESP. Illegal op codes skip the ALU
// and answer one cycle later with rsp_err set.
//
// Optional build macro ALU_SHARE_STATS_EN adds stat_busy_cnt and
// stat_grant_cnt (per-requester 16-bit grant counters).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/ready  per-requester request handshake
//   req_a/b/op       per-requester operands and op code (slice i = requester i)
//   rsp_valid/ready  per-requester response handshake
//   rsp_result/zero/err  shared response payload, qualified by rsp_valid
//   alu_a/b/op       to the ALU; alu_result/zero from the ALU (registered)
// -----------------------------------------------------------------------------
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*3-1:0]     req_op,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_err,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_op,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [31:0]            stat_busy_cnt,
  output logic [N_REQ*16-1:0]    stat_grant_cnt
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state, state_next;
  logic [IDX_W-1:0] rr_ptr, owner, win_idx;
  logic [N_REQ-1:0] win_grant;
  logic             win_any, arb_en, sel_legal;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;

  // Gating with rst_n keeps req_ready low for the whole time reset is held,
  // even though the state register already reads IDLE.
  assign arb_en = (state == IDLE) && rst_n;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .en          (arb_en),
    .grant       (win_grant),
    .idx         (win_idx),
    .grant_valid (win_any)
  );

  assign req_ready = win_grant;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_ADD;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  assign sel_legal = is_legal_op(sel_op);

  // NOTE: asynchronous active-low reset; every register in this block is
  // listed in the reset branch so an abort leaves no stale state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rsp_valid  = '0;
    case (state)
      IDLE: if (win_any) state_next = sel_legal ? EXEC : RESP;
      EXEC: state_next = CAPT;
      CAPT: state_next = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The alu_* registers double as the operand latch: they load only for a
  // legal op, so they hold their last value otherwise and an illegal op never
  // disturbs the ALU.
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      owner      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (win_any) begin
        owner  <= win_idx;
        rr_ptr <= (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
        if (sel_legal) begin
          alu_a  <= sel_a;
          alu_b  <= sel_b;
          alu_op <= sel_op;
        end else begin
          rsp_result <= '0;
          rsp_zero   <= 1'b0;
          rsp_err    <= 1'b1;
        end
      end
      if (state == CAPT) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= 1'b0;
      end
    end
  end

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_busy_cnt  <= '0;
      stat_grant_cnt <= '0;
    end else begin
      if (state != IDLE) stat_busy_cnt <= stat_busy_cnt + 32'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (win_grant[i]) stat_grant_cnt[i*16 +: 16] <= stat_grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
